axi_trans_sched: RTL

AXI_TRANS_SCHED -- requirements
Module: axi_trans_sched

---
 rtl/axi_ctrl_pkg.sv | 51 +++++
 rtl/axi_trans_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_ctrl_pkg.sv
// Shared definitions for the AXI transaction scheduler.
//   - sched_state_e : scheduler FSM states
//   - grant_e       : arbitration grant (LS request FIFO or SS stream FIFO)
//   - field offsets : bit positions inside the LS and SS FIFO entries
//   - helpers       : LM address composition and saturating beat counter
package axi_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLsWr,
    StLsRd,
    StSsTx
  } sched_state_e;

  typedef enum logic {
    GNT_LS,
    GNT_SS
  } grant_e;

  // LS entry: [51] 1=write/0=read, [50:36] addr, [35:4] wdata, [3:0] wstrb
  localparam int unsigned LsEntryW  = 52;
  localparam int unsigned LsWrBit   = 51;
  localparam int unsigned LsAddrMsb = 50;
  localparam int unsigned LsAddrLsb = 36;
  localparam int unsigned LsDataMsb = 35;
  localparam int unsigned LsDataLsb = 4;
  localparam int unsigned LsStrbMsb = 3;
  localparam int unsigned LsStrbLsb = 0;

  // SS entry: [44:43] unused, [42:11] data, [10:7] tstrb, [6:3] tkeep, [2:1] user, [0] tlast
  localparam int unsigned SsEntryW  = 45;
  localparam int unsigned SsDataMsb = 42;
  localparam int unsigned SsDataLsb = 11;
  localparam int unsigned SsStrbMsb = 10;
  localparam int unsigned SsStrbLsb = 7;
  localparam int unsigned SsKeepMsb = 6;
  localparam int unsigned SsKeepLsb = 3;
  localparam int unsigned SsUserMsb = 2;
  localparam int unsigned SsUserLsb = 1;
  localparam int unsigned SsLastBit = 0;

  // LM window: upper 17 bits come from the base, lower 15 from the request.
  function automatic logic [31:0] lm_addr(input logic [16:0] prefix, input logic [14:0] offs);
    return {prefix, offs};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? 8'hFF : val + 8'd1;
  endfunction

endpackage

// File: rtl/axi_trans_sched.sv
// AXI transaction scheduler.
// Arbitrates between an LS request FIFO (LM reads/writes) and an SS stream FIFO (beats forwarded
// to SM), round-robin on ties. One transaction is in flight at a time; SS may hold the grant for
// up to SS_MAX_BURST consecutive beats of one packet.
// Ports:
//   axi_aclk, axi_areset                 clock, asynchronous active-high reset
//   ls_rd_vld/ls_rd_data/ls_rd_rdy       LS FIFO head and pop
//   ss_rd_vld/ss_rd_data/ss_rd_rdy       SS FIFO head and pop
//   bk_lm_w*                             LM write request (start pulse + addr/data/strb), wdone
//   bk_lm_r*                             LM read request (start pulse + addr), rdata/rdone
//   bk_ls_rdata/bk_ls_rdone              read data returned to LS
//   bk_sm_*                              SM beat (start pulse + data/tstrb/tkeep/user), done
module axi_trans_sched
  import axi_ctrl_pkg::*;
#(
  parameter logic [31:0] LM_BASE_ADDR = 32'h3000_0000,
  parameter int unsigned SS_MAX_BURST = 8
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic                ls_rd_vld,
  input  logic [LsEntryW-1:0] ls_rd_data,
  output logic                ls_rd_rdy,
  input  logic                ss_rd_vld,
  input  logic [SsEntryW-1:0] ss_rd_data,
  output logic                ss_rd_rdy,
  output logic                bk_lm_wstart,
  output logic [31:0]         bk_lm_waddr,
  output logic [31:0]         bk_lm_wdata,
  output logic [3:0]          bk_lm_wstrb,
  input  logic                bk_lm_wdone,
  output logic                bk_lm_rstart,
  output logic [31:0]         bk_lm_raddr,
  input  logic [31:0]         bk_lm_rdata,
  input  logic                bk_lm_rdone,
  output logic [31:0]         bk_ls_rdata,
  output logic                bk_ls_rdone,
  output logic                bk_sm_start,
  output logic [31:0]         bk_sm_data,
  output logic [3:0]          bk_sm_tstrb,
  output logic [3:0]          bk_sm_tkeep,
  output logic [1:0]          bk_sm_user,
  input  logic                bk_sm_done
);

  localparam logic [7:0] MaxBurst = SS_MAX_BURST[7:0];

  sched_state_e state_q, state_d;
  grant_e       last_grant_q, last_grant_d;
  grant_e       gnt;
  logic [7:0]   beat_cnt_q, beat_cnt_d;

  logic        wstart_q, rstart_q, sm_start_q, ls_rdone_q;
  logic [31:0] waddr_q, wdata_q, raddr_q, ls_rdata_q, sm_data_q;
  logic [3:0]  wstrb_q, sm_tstrb_q, sm_tkeep_q;
  logic [1:0]  sm_user_q;
  logic        sm_last_q;

  logic ls_pop, ss_pop_idle, ss_cont;
  logic wr_done, rd_done, sm_done;

  // Upper SS bits carry no meaning for this block.
  logic unused_ss_bits;
  assign unused_ss_bits = ^ss_rd_data[SsEntryW-1:SsDataMsb+1];

  // Round-robin: on a tie, the source that did not win last time gets the grant.
  always_comb begin
    gnt = GNT_LS;
    if (ls_rd_vld && ss_rd_vld) begin
      gnt = (last_grant_q == GNT_SS) ? GNT_LS : GNT_SS;
    end else if (ss_rd_vld) begin
      gnt = GNT_SS;
    end
  end

  // Done inputs count only in their wait state and never in the start cycle itself.
  assign wr_done = (state_q == StLsWr) && !wstart_q   && bk_lm_wdone;
  assign rd_done = (state_q == StLsRd) && !rstart_q   && bk_lm_rdone;
  assign sm_done = (state_q == StSsTx) && !sm_start_q && bk_sm_done;

  // Continue the SS packet only while it is unfinished, within burst budget and data is ready.
  assign ss_cont = sm_done && !sm_last_q && (beat_cnt_q < MaxBurst) && ss_rd_vld;

  // State register
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q      <= StIdle;
      last_grant_q <= GNT_SS;
      beat_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ls_pop) begin
          state_d = ls_rd_data[LsWrBit] ? StLsWr : StLsRd;
        end else if (ss_pop_idle) begin
          state_d    = StSsTx;
          beat_cnt_d = sat_inc8(beat_cnt_q);
        end
      end
      StLsWr: begin
        if (wr_done) begin
          state_d      = StIdle;
          last_grant_d = GNT_LS;
        end
      end
      StLsRd: begin
        if (rd_done) begin
          state_d      = StIdle;
          last_grant_d = GNT_LS;
        end
      end
      StSsTx: begin
        if (ss_cont) begin
          beat_cnt_d = sat_inc8(beat_cnt_q);
        end else if (sm_done) begin
          state_d      = StIdle;
          last_grant_d = GNT_SS;
          beat_cnt_d   = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: FIFO pops are combinational with vld, so the entry is captured on this edge.
  always_comb begin
    ls_pop      = 1'b0;
    ss_pop_idle = 1'b0;
    if (!axi_areset && (state_q == StIdle)) begin
      ls_pop      = ls_rd_vld && (gnt == GNT_LS);
      ss_pop_idle = ss_rd_vld && (gnt == GNT_SS);
    end
    ls_rd_rdy = ls_pop;
    ss_rd_rdy = ss_pop_idle || (!axi_areset && ss_cont);
  end

  // Datapath: start pulses land one cycle after the pop; payload holds until the next pop.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wstart_q   <= 1'b0;
      rstart_q   <= 1'b0;
      sm_start_q <= 1'b0;
      ls_rdone_q <= 1'b0;
      waddr_q    <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      raddr_q    <= 32'd0;
      ls_rdata_q <= 32'd0;
      sm_data_q  <= 32'd0;
      sm_tstrb_q <= 4'd0;
      sm_tkeep_q <= 4'd0;
      sm_user_q  <= 2'd0;
      sm_last_q  <= 1'b0;
    end else begin
      wstart_q   <= ls_pop && ls_rd_data[LsWrBit];
      rstart_q   <= ls_pop && !ls_rd_data[LsWrBit];
      sm_start_q <= ss_rd_rdy;
      ls_rdone_q <= rd_done;
      if (ls_pop) begin
        if (ls_rd_data[LsWrBit]) begin
          waddr_q <= lm_addr(LM_BASE_ADDR[31:15], ls_rd_data[LsAddrMsb:LsAddrLsb]);
          wdata_q <= ls_rd_data[LsDataMsb:LsDataLsb];
          wstrb_q <= ls_rd_data[LsStrbMsb:LsStrbLsb];
        end else begin
          raddr_q <= lm_addr(LM_BASE_ADDR[31:15], ls_rd_data[LsAddrMsb:LsAddrLsb]);
        end
      end
      if (rd_done) begin
        ls_rdata_q <= bk_lm_rdata;
      end
      if (ss_rd_rdy) begin
        sm_data_q  <= ss_rd_data[SsDataMsb:SsDataLsb];
        sm_tstrb_q <= ss_rd_data[SsStrbMsb:SsStrbLsb];
        sm_tkeep_q <= ss_rd_data[SsKeepMsb:SsKeepLsb];
        sm_user_q  <= ss_rd_data[SsUserMsb:SsUserLsb];
        sm_last_q  <= ss_rd_data[SsLastBit];
      end
    end
  end

  assign bk_lm_wstart = wstart_q;
  assign bk_lm_waddr  = waddr_q;
  assign bk_lm_wdata  = wdata_q;
  assign bk_lm_wstrb  = wstrb_q;
  assign bk_lm_rstart = rstart_q;
  assign bk_lm_raddr  = raddr_q;
  assign bk_ls_rdata  = ls_rdata_q;
  assign bk_ls_rdone  = ls_rdone_q;
  assign bk_sm_start  = sm_start_q;
  assign bk_sm_data   = sm_data_q;
  assign bk_sm_tstrb  = sm_tstrb_q;
  assign bk_sm_tkeep  = sm_tkeep_q;
  assign bk_sm_user   = sm_user_q;

endmodule
